// File: rtl/dvp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dvp_pkg
//  Brief    : Shared FSM states, pattern codes and bar colours for the DVP source.
//  Revision : 1.0 - initial release
// ============================================================================
package dvp_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_GAP  = 3'd1,
      S_PRE  = 3'd2,
      S_LINE = 3'd3,
      S_HBLK = 3'd4,
      S_POST = 3'd5,
      S_END  = 3'd6
   } state_t;

   localparam logic [1:0] PAT_BARS  = 2'd0;
   localparam logic [1:0] PAT_RAMP  = 2'd1;
   localparam logic [1:0] PAT_CHECK = 2'd2;
   localparam logic [1:0] PAT_SOLID = 2'd3;

   localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
   localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
   localparam logic [15:0] BAR_CYAN    = 16'h07FF;
   localparam logic [15:0] BAR_GREEN   = 16'h07E0;
   localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
   localparam logic [15:0] BAR_RED     = 16'hF800;
   localparam logic [15:0] BAR_BLUE    = 16'h001F;
   localparam logic [15:0] BAR_BLACK   = 16'h0000;

   function automatic logic [15:0] bar_colour(input logic [2:0] idx);
      logic [15:0] col;
      case (idx)
         3'd0:    col = BAR_WHITE;
         3'd1:    col = BAR_YELLOW;
         3'd2:    col = BAR_CYAN;
         3'd3:    col = BAR_GREEN;
         3'd4:    col = BAR_MAGENTA;
         3'd5:    col = BAR_RED;
         3'd6:    col = BAR_BLUE;
         default: col = BAR_BLACK;
      endcase
      return col;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dvp_pattern_pix.sv
`default_nettype none
// ============================================================================
//  Module   : dvp_pattern_pix
//  Brief    : Registered RGB565 test-pattern pixel generator.
//  Revision : 1.0 - initial release
// ============================================================================
module dvp_pattern_pix
   import dvp_pkg::*;
(
   input  logic        pclk,
   input  logic        rst,
   input  logic [1:0]  pattern_i,
   input  logic [15:0] solid_i,
   input  logic [11:0] x_i,
   input  logic [10:0] y_i,
   input  logic [2:0]  bar_i,
   output logic [15:0] pix_o
);

   logic [15:0] pix_d;
   logic [15:0] pix_q;
   logic        w_unused;

   // Only bit 4 of y selects the checker square.
   assign w_unused = &{1'b0, y_i[10:5], y_i[3:0]};

   always_comb begin
      pix_d = 16'h0000;
      case (pattern_i)
         PAT_BARS:  pix_d = bar_colour(bar_i);
         PAT_RAMP:  pix_d = {4'h0, x_i};
         PAT_CHECK: pix_d = (x_i[4] ^ y_i[4]) ? 16'hFFFF : 16'h0000;
         default:   pix_d = solid_i;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (rst) pix_q <= 16'h0000;
      else     pix_q <= pix_d;
   end

   assign pix_o = pix_q;

endmodule
`default_nettype wire

// File: rtl/dvp_pattern_source.sv
`default_nettype none
// ============================================================================
//  Module   : dvp_pattern_source
//  Brief    : DVP camera-bus emulator: frame FSM and RGB565 byte serialiser.
//  Revision : 1.0 - initial release
// ============================================================================
module dvp_pattern_source
   import dvp_pkg::*;
#(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int H_BLANK  = 144,
   parameter int V_PRE    = 2,
   parameter int V_POST   = 2,
   parameter int VS_GAP   = 3000
)(
   input  logic        pclk,
   input  logic        rst,
   input  logic        en,
   input  logic [1:0]  pattern_sel,
   input  logic [15:0] solid_rgb,
   output logic        vsync,
   output logic        href,
   output logic [7:0]  camera_data,
   output logic        frame_done,
   output logic [15:0] frame_count
);

   localparam int LINE_T = 2 * H_ACTIVE + H_BLANK;
   localparam int BW     = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

   localparam logic [15:0] c_gap_last  = 16'(VS_GAP - 1);
   localparam logic [15:0] c_pre_last  = 16'(V_PRE * LINE_T - 1);
   localparam logic [15:0] c_post_last = 16'(V_POST * LINE_T - 1);
   localparam logic [15:0] c_hblk_last = 16'(H_BLANK - 1);
   localparam logic [11:0] c_b_last    = 12'(2 * H_ACTIVE - 1);
   localparam logic [11:0] c_bw_last   = 12'(BW - 1);
   localparam logic [10:0] c_y_last    = 11'(V_ACTIVE - 1);

   generate
      if (H_ACTIVE < 1 || 2 * H_ACTIVE > 4096 || V_ACTIVE < 1 || V_ACTIVE > 2048 ||
          H_BLANK < 1 || H_BLANK > 65536 || V_PRE < 1 || V_PRE * LINE_T > 65536 ||
          V_POST < 1 || V_POST * LINE_T > 65536 || VS_GAP < 1 || VS_GAP > 65536)
      begin : g_param_check
         $error("dvp_pattern_source: timing parameters exceed counter widths");
      end
   endgenerate

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [11:0] b_q, b_d;
   logic [10:0] y_q, y_d;
   logic [2:0]  bar_q, bar_d;
   logic [11:0] barpix_q, barpix_d;
   logic [1:0]  pat_q, pat_d;
   logic [15:0] solid_q, solid_d;

   logic        vsync_q, href_q, done_q;
   logic [7:0]  data_q;
   logic [15:0] fcount_q;
   logic [15:0] pix;
   logic [7:0]  byte_sel;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      b_d      = b_q;
      y_d      = y_q;
      bar_d    = bar_q;
      barpix_d = barpix_q;
      pat_d    = pat_q;
      solid_d  = solid_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = 16'd0;
            y_d   = 11'd0;
            if (en) begin
               pat_d   = pattern_sel;
               solid_d = solid_rgb;
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            if (cnt_q == c_gap_last) begin
               cnt_d   = 16'd0;
               state_d = S_PRE;
            end else cnt_d = cnt_q + 16'd1;
         end
         S_PRE: begin
            if (cnt_q == c_pre_last) begin
               cnt_d    = 16'd0;
               b_d      = 12'd0;
               bar_d    = 3'd0;
               barpix_d = 12'd0;
               state_d  = S_LINE;
            end else cnt_d = cnt_q + 16'd1;
         end
         S_LINE: begin
            if (b_q == c_b_last) begin
               b_d      = 12'd0;
               bar_d    = 3'd0;
               barpix_d = 12'd0;
               state_d  = S_HBLK;
            end else begin
               b_d = b_q + 12'd1;
               // A pixel ends on its odd byte; the bar index saturates on the last bar.
               if (b_q[0]) begin
                  if (barpix_q == c_bw_last) begin
                     barpix_d = 12'd0;
                     if (bar_q != 3'd7) bar_d = bar_q + 3'd1;
                  end else barpix_d = barpix_q + 12'd1;
               end
            end
         end
         S_HBLK: begin
            if (cnt_q == c_hblk_last) begin
               cnt_d = 16'd0;
               if (y_q == c_y_last) begin
                  y_d     = 11'd0;
                  state_d = S_POST;
               end else begin
                  y_d     = y_q + 11'd1;
                  state_d = S_LINE;
               end
            end else cnt_d = cnt_q + 16'd1;
         end
         S_POST: begin
            if (cnt_q == c_post_last) begin
               cnt_d   = 16'd0;
               state_d = S_END;
            end else cnt_d = cnt_q + 16'd1;
         end
         S_END: begin
            cnt_d = 16'd0;
            y_d   = 11'd0;
            if (en) begin
               pat_d   = pattern_sel;
               solid_d = solid_rgb;
               state_d = S_GAP;
            end else state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Fed with next-state coordinates so the pixel is ready when its byte goes out.
   dvp_pattern_pix u_pix (
      .pclk      (pclk),
      .rst       (rst),
      .pattern_i (pat_q),
      .solid_i   (solid_q),
      .x_i       ({1'b0, b_d[11:1]}),
      .y_i       (y_d),
      .bar_i     (bar_d),
      .pix_o     (pix)
   );

   assign byte_sel = b_q[0] ? pix[7:0] : pix[15:8];

   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= 16'd0;
         b_q      <= 12'd0;
         y_q      <= 11'd0;
         bar_q    <= 3'd0;
         barpix_q <= 12'd0;
         pat_q    <= 2'd0;
         solid_q  <= 16'd0;
         vsync_q  <= 1'b0;
         href_q   <= 1'b0;
         data_q   <= 8'h00;
         done_q   <= 1'b0;
         fcount_q <= 16'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         b_q      <= b_d;
         y_q      <= y_d;
         bar_q    <= bar_d;
         barpix_q <= barpix_d;
         pat_q    <= pat_d;
         solid_q  <= solid_d;
         vsync_q  <= (state_q == S_PRE) || (state_q == S_LINE) ||
                     (state_q == S_HBLK) || (state_q == S_POST);
         href_q   <= (state_q == S_LINE);
         data_q   <= (state_q == S_LINE) ? byte_sel : 8'h00;
         done_q   <= (state_q == S_END);
         if (state_q == S_END) fcount_q <= fcount_q + 16'd1;
      end
   end

   assign vsync       = vsync_q;
   assign href        = href_q;
   assign camera_data = data_q;
   assign frame_done  = done_q;
   assign frame_count = fcount_q;

endmodule
`default_nettype wire

// File: tb/tb_dvp_pattern_source.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dvp_pattern_source
//  Brief    : Directed self-checking bench for dvp_pattern_source.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dvp_pattern_source;

   localparam int FRAME_T = 147;
   localparam int CAP2_N  = 2410;

   logic        pclk = 1'b0;
   logic        rst, en, en2;
   logic [1:0]  pattern_sel;
   logic [15:0] solid_rgb;

   logic        vsync, href, frame_done;
   logic [7:0]  camera_data;
   logic [15:0] frame_count;
   logic        vsync2, href2, frame_done2;
   logic [7:0]  camera_data2;
   logic [15:0] frame_count2;

   int n_cmp = 0;
   int n_bad = 0;

   logic [2:0]  ctl_a [FRAME_T];
   logic [7:0]  dat_a [FRAME_T];
   logic [15:0] fc_a  [FRAME_T];
   logic [7:0]  cap2  [CAP2_N];

   always #5 pclk = ~pclk;

   dvp_pattern_source #(
      .H_ACTIVE(8), .V_ACTIVE(4), .H_BLANK(4), .V_PRE(2), .V_POST(1), .VS_GAP(6)
   ) dut (
      .pclk(pclk), .rst(rst), .en(en), .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
      .vsync(vsync), .href(href), .camera_data(camera_data),
      .frame_done(frame_done), .frame_count(frame_count)
   );

   dvp_pattern_source #(
      .H_ACTIVE(64), .V_ACTIVE(32), .H_BLANK(4), .V_PRE(2), .V_POST(1), .VS_GAP(6)
   ) dut_chk (
      .pclk(pclk), .rst(rst), .en(en2), .pattern_sel(2'd2), .solid_rgb(16'h0000),
      .vsync(vsync2), .href(href2), .camera_data(camera_data2),
      .frame_done(frame_done2), .frame_count(frame_count2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   // Steps until a vsync rising edge on the selected DUT; n is the step count.
   task automatic wait_rise(input bit sel, output int n);
      bit prev;
      prev = sel ? vsync2 : vsync;
      n = 0;
      while (n < 3000) begin
         step();
         n++;
         if (!prev && (sel ? vsync2 : vsync)) break;
         prev = sel ? vsync2 : vsync;
      end
   endtask

   task automatic capture(input int chg_i, input logic [1:0] chg_pat, input int drop_i);
      for (int i = 0; i < FRAME_T; i++) begin
         ctl_a[i] = {vsync, href, frame_done};
         dat_a[i] = camera_data;
         fc_a[i]  = frame_count;
         if (i == chg_i)  pattern_sel = chg_pat;
         if (i == drop_i) en = 1'b0;
         if (i < FRAME_T - 1) step();
      end
   endtask

   function automatic logic [7:0] exp_byte(input logic [1:0] pat, input logic [15:0] solid,
                                           input int k);
      logic [127:0] row;
      row = 128'hFFFF_FFE0_07FF_07E0_F81F_F800_001F_0000;
      case (pat)
         2'd0:    return row[127 - 8 * k -: 8];
         2'd1:    return k[0] ? 8'(k >> 1) : 8'h00;
         2'd3:    return k[0] ? solid[7:0] : solid[15:8];
         default: return 8'h00;
      endcase
   endfunction

   task automatic check_frame(input string nm, input logic [1:0] pat, input logic [15:0] solid,
                              input logic [15:0] fc);
      logic       hr;
      logic [7:0] ed;
      check({nm, "_fc_start"}, fc_a[0], fc - 16'd1);
      check({nm, "_fc_end"}, fc_a[140], fc);
      for (int i = 0; i < FRAME_T; i++) begin
         hr = (i >= 40) && (i < 120) && (((i - 40) % 20) < 16);
         ed = hr ? exp_byte(pat, solid, (i - 40) % 20) : 8'h00;
         check($sformatf("%s_ctl[%0d]", nm, i), ctl_a[i], {(i < 140), hr, (i == 140)});
         check($sformatf("%s_data[%0d]", nm, i), dat_a[i], ed);
      end
   endtask

   initial begin
      int n;
      int hi;
      rst = 1'b1; en = 1'b0; en2 = 1'b0; pattern_sel = 2'd0; solid_rgb = 16'hABCD;
      repeat (3) step();
      check("reset_vsync", vsync, 0);
      check("reset_href", href, 0);
      check("reset_data", camera_data, 0);
      check("reset_done", frame_done, 0);
      check("reset_count", frame_count, 0);

      rst = 1'b0; en = 1'b1;
      wait_rise(1'b0, n);
      check("first_rise_delay", n, 8);
      // Frame 1 stays bars although the selector moves to solid on line 2.
      capture(85, 2'd3, -1);
      check_frame("f1_bars", 2'd0, 16'hABCD, 16'd1);
      wait_rise(1'b0, n);
      check("period_f2", n, 1);
      capture(85, 2'd1, -1);
      check_frame("f2_solid", 2'd3, 16'hABCD, 16'd2);
      wait_rise(1'b0, n);
      check("period_f3", n, 1);
      capture(-1, 2'd1, -1);
      check_frame("f3_ramp", 2'd1, 16'hABCD, 16'd3);
      wait_rise(1'b0, n);
      check("period_f4", n, 1);
      capture(-1, 2'd1, 10);
      check_frame("f4_en_drop", 2'd1, 16'hABCD, 16'd4);

      hi = 0;
      for (int i = 0; i < 400; i++) begin
         step();
         if (vsync || href || frame_done) hi++;
      end
      check("idle_quiet", hi, 0);
      check("idle_count_frozen", frame_count, 4);

      en = 1'b1;
      wait_rise(1'b0, n);
      check("idle_restart_delay", n, 8);
      repeat (45) step();
      check("byte5_href", href, 1);
      check("byte5_data", camera_data, 8'h02);
      rst = 1'b1;
      step();
      check("midrst_vsync", vsync, 0);
      check("midrst_href", href, 0);
      check("midrst_data", camera_data, 0);
      check("midrst_done", frame_done, 0);
      check("midrst_count", frame_count, 0);
      rst = 1'b0;
      wait_rise(1'b0, n);
      check("rst_restart_delay", n, 8);
      capture(-1, 2'd1, -1);
      check_frame("f6_after_rst", 2'd1, 16'hABCD, 16'd1);

      en = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0; en2 = 1'b1;
      wait_rise(1'b1, n);
      check("chk_rise_delay", n, 8);
      for (int i = 0; i < CAP2_N; i++) begin
         cap2[i] = camera_data2;
         if (i < CAP2_N - 1) step();
      end
      check("chk_pix_0_0", {cap2[264], cap2[265]}, 16'h0000);
      check("chk_pix_16_0", {cap2[296], cap2[297]}, 16'hFFFF);
      check("chk_pix_0_16", {cap2[2376], cap2[2377]}, 16'hFFFF);
      check("chk_pix_16_16", {cap2[2408], cap2[2409]}, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
